// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition trigger controller: state encoding,
// trigger mode codes and the PSRAM word-address width.
package acq_pkg;

  localparam int ACQ_ADDR_WIDTH = 23;

  localparam logic [7:0] TRIG_THRESH = 8'h54;
  localparam logic [7:0] TRIG_BUTTON = 8'h42;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE_FILL = 3'd1,
    ARMED    = 3'd2,
    POST     = 3'd3,
    DONE     = 3'd4
  } acq_state_e;

endpackage

// File: rtl/acq_trigger_ctrl_if.sv
// PSRAM write channel: one request outstanding, completed by a one-cycle ack.
interface acq_trigger_ctrl_if
  import acq_pkg::*;
#(
  parameter int ADDR_WIDTH = ACQ_ADDR_WIDTH
) ();

  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]           wr_data;
  logic                  wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input  wr_ack);
  modport slave  (input  wr_req, input  wr_addr, input  wr_data, output wr_ack);

endinterface

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer for the asynchronous pushbutton followed by a
// registered one-cycle rising-edge pulse.
module button_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic edge_o
);

  logic [2:0] sync_q, sync_d;
  logic       edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[1:0], btn_i};
    edge_d = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/acq_trigger_ctrl.sv
// Acquisition controller: streams ADC samples into a circular PSRAM buffer,
// detects the trigger and reports where the pre/post-trigger record starts.
module acq_trigger_ctrl
  import acq_pkg::*;
#(
  parameter int ADC_WIDTH  = 12,
  parameter int ADDR_WIDTH = ACQ_ADDR_WIDTH,
  parameter int BUF_DEPTH  = 8388608
) (
  input  logic                  clk_PSRAM,
  input  logic                  rst_n,
  input  logic                  flag_acq,
  input  logic [7:0]            trigger,
  input  logic [12:0]           threshold,
  input  logic [23:0]           samples_before,
  input  logic [23:0]           samples_after,
  input  logic                  button,
  input  logic                  adc_valid,
  input  logic [ADC_WIDTH-1:0]  adc_data,
  acq_trigger_ctrl_if.master    wr,
  output logic                  busy,
  output logic                  acq_done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  overrun,
  output logic                  cfg_err
);

  localparam logic [24:0]           DEPTH_W   = 25'(BUF_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BUF_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};

  acq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  wr_req_q, wr_req_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]           wr_data_q, wr_data_d;
  logic [7:0]            mode_q, mode_d;
  logic [12:0]           thresh_q, thresh_d;
  logic [23:0]           before_q, before_d;
  logic [23:0]           after_q, after_d;
  logic [23:0]           cnt_q, cnt_d;
  logic [ADC_WIDTH-1:0]  prev_q, prev_d;
  logic                  btn_pend_q, btn_pend_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
  logic                  overrun_q, overrun_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  acq_done_q, acq_done_d;
  logic                  busy_q, busy_d;

  logic        btn_edge_s;
  logic        active_s;
  logic        accept_s;
  logic        ack_s;
  logic        fire_s;
  logic        cfg_ok_s;
  logic [24:0] need_s;
  logic [24:0] ptr_w_s;
  logic [24:0] back_s;

  button_sync_edge u_button_sync_edge (
    .clk    (clk_PSRAM),
    .rst_n  (rst_n),
    .btn_i  (button),
    .edge_o (btn_edge_s)
  );

  // Sample qualifiers, trigger condition and the modulo record-start address.
  always_comb begin
    active_s = (state_q == PRE_FILL) || (state_q == ARMED) || (state_q == POST);
    accept_s = active_s && adc_valid && !wr_req_q;
    ack_s    = wr_req_q && wr.wr_ack;
    need_s   = {1'b0, samples_before} + {1'b0, samples_after} + 25'd1;
    cfg_ok_s = (need_s <= DEPTH_W);
    ptr_w_s  = 25'(ptr_q);
    if (ptr_w_s >= {1'b0, before_q}) begin
      back_s = ptr_w_s - {1'b0, before_q};
    end else begin
      back_s = ptr_w_s + DEPTH_W - {1'b0, before_q};
    end
    case (mode_q)
      TRIG_THRESH: fire_s = (13'(prev_q) < thresh_q) && (13'(adc_data) >= thresh_q);
      TRIG_BUTTON: fire_s = btn_pend_q;
      default:     fire_s = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    wr_req_d     = wr_req_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    mode_d       = mode_q;
    thresh_d     = thresh_q;
    before_d     = before_q;
    after_d      = after_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    btn_pend_d   = btn_pend_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    overrun_d    = overrun_q;
    cfg_err_d    = cfg_err_q;

    if (accept_s) begin
      wr_req_d  = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = 16'(adc_data);
    end else if (ack_s) begin
      wr_req_d = 1'b0;
      ptr_d    = (ptr_q == LAST_ADDR) ? ZERO_ADDR : ptr_q + ADDR_WIDTH'(1'b1);
    end else begin
      wr_req_d = wr_req_q;
    end

    // A sample arriving while the previous write is still pending is lost.
    if (active_s && adc_valid && wr_req_q) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      IDLE: begin
        if (flag_acq && cfg_ok_s) begin
          mode_d       = trigger;
          thresh_d     = threshold;
          before_d     = samples_before;
          after_d      = samples_after;
          ptr_d        = ZERO_ADDR;
          cnt_d        = 24'd0;
          btn_pend_d   = 1'b0;
          overrun_d    = 1'b0;
          cfg_err_d    = 1'b0;
          trig_addr_d  = ZERO_ADDR;
          start_addr_d = ZERO_ADDR;
          state_d      = (samples_before == 24'd0) ? ARMED : PRE_FILL;
        end else if (flag_acq) begin
          cfg_err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      PRE_FILL: begin
        btn_pend_d = 1'b0;
        if (accept_s) begin
          prev_d = adc_data;
          cnt_d  = cnt_q + 24'd1;
          if ((cnt_q + 24'd1) == before_q) begin
            state_d = ARMED;
          end else begin
            state_d = PRE_FILL;
          end
        end else begin
          state_d = PRE_FILL;
        end
      end
      ARMED: begin
        if (btn_edge_s) begin
          btn_pend_d = 1'b1;
        end else begin
          btn_pend_d = btn_pend_q;
        end
        if (accept_s && fire_s) begin
          prev_d       = adc_data;
          trig_addr_d  = ptr_q;
          start_addr_d = ADDR_WIDTH'(back_s);
          cnt_d        = 24'd0;
          btn_pend_d   = 1'b0;
          state_d      = POST;
        end else if (accept_s) begin
          prev_d = adc_data;
        end else begin
          state_d = ARMED;
        end
      end
      POST: begin
        // cnt_q numbers the single outstanding write, so its ack closes the record.
        if (accept_s) begin
          cnt_d = cnt_q + 24'd1;
        end else if (ack_s && (cnt_q == after_q)) begin
          state_d = DONE;
        end else begin
          state_d = POST;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    acq_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_PSRAM) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= ZERO_ADDR;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= ZERO_ADDR;
      wr_data_q    <= 16'd0;
      mode_q       <= 8'd0;
      thresh_q     <= 13'd0;
      before_q     <= 24'd0;
      after_q      <= 24'd0;
      cnt_q        <= 24'd0;
      prev_q       <= {ADC_WIDTH{1'b0}};
      btn_pend_q   <= 1'b0;
      trig_addr_q  <= ZERO_ADDR;
      start_addr_q <= ZERO_ADDR;
      overrun_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      acq_done_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      mode_q       <= mode_d;
      thresh_q     <= thresh_d;
      before_q     <= before_d;
      after_q      <= after_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      btn_pend_q   <= btn_pend_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      overrun_q    <= overrun_d;
      cfg_err_q    <= cfg_err_d;
      acq_done_q   <= acq_done_d;
      busy_q       <= busy_d;
    end
  end

  assign wr.wr_req  = wr_req_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;
  assign busy       = busy_q;
  assign acq_done   = acq_done_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;
  assign overrun    = overrun_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: doc/acq_trigger_ctrl.md
Name: acq_trigger_ctrl

Overview:
Acquisition controller directly downstream of the UART command receiver. It consumes the start pulse and the trigger, threshold and pre/post sample-count settings. It streams ADC samples into a circular PSRAM buffer, detects the trigger, captures the requested pre- and post-trigger windows, then reports where the record starts so the readback path can send it out over UART.

Parameters:
ADC_WIDTH, 12, ADC sample width; zero-extended to 16 bits on wr_data.
ADDR_WIDTH, 23, PSRAM word-address width.
BUF_DEPTH, 8388608, circular buffer length in words; wrap point for wr_addr.

Ports:
clk_PSRAM  in  1  system clock, same domain as the UART and PSRAM controller
rst_n  in  1  synchronous active-low reset
flag_acq  in  1  one-cycle start pulse from UART
trigger  in  8  trigger mode: 8'h54 'T' threshold, 8'h42 'B' button, any other value = immediate
threshold  in  13  threshold; bit12 set means the threshold can never be reached
samples_before  in  24  pre-trigger sample count
samples_after  in  24  post-trigger sample count, excluding the trigger sample
button  in  1  asynchronous pushbutton, active-high
adc_valid  in  1  one-cycle strobe; adc_data is valid when high
adc_data  in  ADC_WIDTH  ADC sample
wr_req  out  1  PSRAM write request; held high until wr_ack
wr_addr  out  ADDR_WIDTH  write word address
wr_data  out  16  write data
wr_ack  in  1  one-cycle write-complete pulse from the PSRAM controller
busy  out  1  high in any state other than IDLE
acq_done  out  1  one-cycle pulse when the record is complete
trig_addr  out  ADDR_WIDTH  address of the trigger sample
start_addr  out  ADDR_WIDTH  first address of the record: (trig_addr - samples_before) mod BUF_DEPTH
overrun  out  1  sticky flag: a sample arrived while a write was pending
cfg_err  out  1  sticky flag: start rejected because of the requested counts

Behaviour:
- Reset values: every output is 0. State = IDLE, internal write pointer = 0, previous-sample register = 0.
- Reset mid-operation drops wr_req in the same cycle. The PSRAM controller tolerates an abandoned request.
- Start: on flag_acq in IDLE, latch trigger, threshold and both counts, clear overrun, and set the write pointer to 0.
  - If samples_before + samples_after + 1 > BUF_DEPTH (25-bit sum): stay IDLE, set cfg_err, do not touch overrun.
  - Otherwise clear cfg_err and go to PRE_FILL, or to ARMED when samples_before == 0.
  - flag_acq outside IDLE is ignored.
- Sample accept:
  - An adc_valid while wr_req is low loads wr_data = zero-extended adc_data and wr_addr = pointer, and raises wr_req on the next cycle.
  - On wr_ack, drop wr_req and advance the pointer, wrapping from BUF_DEPTH-1 to 0.
  - An adc_valid while wr_req is high drops the sample and sets overrun; counters and trigger evaluation are unaffected.
  - Samples arriving in IDLE or DONE are ignored.
- States:
  - PRE_FILL: count accepted samples. When the count reaches samples_before, go to ARMED. Triggers are not evaluated in this state.
  - ARMED: circular writes continue. Evaluate the trigger on each accepted sample:
    - 'T': fires when prev < threshold and current >= threshold, unsigned 13-bit compare, so it requires a rising crossing.
    - 'B': fires on the first accepted sample after a synchronized rising edge of button. The edge is latched until consumed.
    - Other codes: the first accepted sample in ARMED fires.
    - prev updates on every accepted sample in PRE_FILL and ARMED.
  - When the trigger fires, the triggering sample's address goes to trig_addr, start_addr is computed, the post counter is cleared, and the state goes to POST.
  - POST: count accepted samples after the trigger sample. Enter DONE when the write ack of the sample numbered samples_after arrives; with samples_after == 0, that is the trigger sample's ack.
  - DONE: pulse acq_done for one cycle, then return to IDLE. trig_addr and start_addr hold until the next valid start.
- Boundary cases:
  - Pointer wrap during ARMED is normal operation.
  - start_addr subtraction is modulo BUF_DEPTH.
  - A trigger and a button edge in the same cycle as the PRE_FILL→ARMED transition are not evaluated.
  - A button edge during PRE_FILL is discarded.
  - A wr_ack with no pending request is ignored.

Decomposition:
- Package acq_pkg holds:
  - the state encoding IDLE, PRE_FILL, ARMED, POST, DONE;
  - the trigger codes TRIG_THRESH = 8'h54 and TRIG_BUTTON = 8'h42;
  - the address-width constant shared with the PSRAM controller.
- One sub-module, button_sync_edge: 2-flop synchronizer plus rising-edge pulse generator, reset by rst_n.

Test Plan:
- Threshold trigger: 'T', threshold 100, before 4, after 3; ramp of 0,20,40,…, each acked after 3 cycles → trigger on sample 100 at address 5, trig_addr 5, start_addr 1, acq_done after 9 acks, 0 overruns.
- Button trigger: 'B', before 2, after 2; a button pulse during PRE_FILL is ignored; a pulse in ARMED → the next sample triggers; acq_done after exactly 2 more acks.
- Immediate trigger with zero windows: code 8'h00, before 0, after 0 → first sample triggers, trig_addr 0, start_addr 0, acq_done one cycle after the first ack.
- Wrap with BUF_DEPTH = 8: 'T' with 11 samples below threshold, then a crossing → trig_addr 3 (the 12th sample's address, wrapped), start_addr = (3 - before) mod 8.
- Overrun and config error: adc_valid every cycle with wr_ack delayed 4 cycles → overrun set and samples dropped. Start with before 6, after 2, BUF_DEPTH 8 → cfg_err = 1 and busy stays 0.
- Reset mid-POST: rst_n low for one cycle while wr_req is high → wr_req = 0 and busy = 0 the next cycle, all outputs 0; a new start runs normally.
